// File: rtl/definitions.sv
// Shared definitions for the data-memory path: access size codes and arbiter types.
package definitions;

    // Access size/sign codes understood by data_memory.
    localparam logic [2:0] MEM_BYTE              = 3'b000;
    localparam logic [2:0] MEM_HALFWORD          = 3'b001;
    localparam logic [2:0] MEM_WORD              = 3'b010;
    localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'b100;
    localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_ACK  = 2'd1,
        ST_HALT = 2'd2
    } arb_state_t;

    localparam logic ARB_PORT_CORE = 1'b0;
    localparam logic ARB_PORT_DBG  = 1'b1;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles the debug port has lost to the core.
module arb_starve_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_reg;

    // Clear wins over increment so a grant cycle always restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && !at_limit) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign at_limit = (cnt_reg == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares data_memory between the core Memory stage and a debug/loader port,
// with core priority, a starvation guarantee for debug, and a debug halt mode.
module dmem_arbiter
    import definitions::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Core_Req,
    input  logic        Core_W_En,
    input  logic [2:0]  Core_Control,
    input  logic [31:0] Core_Addr,
    input  logic [31:0] Core_W_Data,
    output logic [31:0] Core_R_Data,
    output logic        Core_Stall,
    input  logic        Dbg_Req,
    input  logic        Dbg_W_En,
    input  logic [2:0]  Dbg_Control,
    input  logic [31:0] Dbg_Addr,
    input  logic [31:0] Dbg_W_Data,
    output logic [31:0] Dbg_R_Data,
    output logic        Dbg_Ack,
    input  logic        Dbg_Halt,
    output logic        Halted,
    output logic        MEM_W_En,
    output logic [2:0]  MEM_Control,
    output logic [31:0] MEM_Addr,
    output logic [31:0] MEM_W_Data,
    input  logic [31:0] MEM_Data_Out
);

    arb_state_t  state_reg;
    logic        halted_reg;
    logic        dbg_ack_reg;
    logic [31:0] dbg_r_data_reg;

    logic core_grant;
    logic dbg_grant;
    logic sel_port;
    logic at_limit;
    logic starve_inc;
    logic starve_clr;

    // Counting only happens while running; any other state restarts it.
    assign starve_inc = (state_reg == ST_RUN) && Dbg_Req && core_grant;
    assign starve_clr = (state_reg != ST_RUN) || !Dbg_Req || dbg_grant;

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (CLK),
        .rst_n    (RST_N),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .at_limit (at_limit)
    );

    always_comb begin
        core_grant = 1'b0;
        dbg_grant  = 1'b0;
        unique case (state_reg)
            ST_RUN: begin
                dbg_grant  = Dbg_Req && (!Core_Req || at_limit);
                core_grant = Core_Req && !dbg_grant;
            end
            // The ack cycle never re-grants debug, so a held Dbg_Req cannot double-write.
            ST_ACK:  core_grant = Core_Req && !halted_reg;
            ST_HALT: dbg_grant  = Dbg_Req;
            default: ;
        endcase
    end

    assign sel_port = dbg_grant ? ARB_PORT_DBG : ARB_PORT_CORE;

    always_comb begin
        MEM_W_En    = 1'b0;
        MEM_Control = Core_Control;
        MEM_Addr    = Core_Addr;
        MEM_W_Data  = '0;
        if (sel_port == ARB_PORT_DBG) begin
            MEM_W_En    = Dbg_W_En;
            MEM_Control = Dbg_Control;
            MEM_Addr    = Dbg_Addr;
            MEM_W_Data  = Dbg_W_Data;
        end else if (core_grant) begin
            MEM_W_En    = Core_W_En;
            MEM_W_Data  = Core_W_Data;
        end
    end

    assign Core_Stall  = Core_Req && !core_grant;
    assign Core_R_Data = MEM_Data_Out;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg      <= ST_RUN;
            halted_reg     <= 1'b0;
            dbg_ack_reg    <= 1'b0;
            dbg_r_data_reg <= '0;
        end else begin
            dbg_ack_reg <= dbg_grant;
            if (dbg_grant) begin
                dbg_r_data_reg <= MEM_Data_Out;
            end
            unique case (state_reg)
                ST_RUN: begin
                    if (dbg_grant) begin
                        state_reg <= ST_ACK;
                    end else if (Dbg_Halt) begin
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                    end
                end
                ST_ACK: begin
                    if (Dbg_Halt) begin
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                    end else begin
                        state_reg  <= ST_RUN;
                        halted_reg <= 1'b0;
                    end
                end
                ST_HALT: begin
                    // Halted stays set through an ack entered from halt.
                    if (dbg_grant) begin
                        state_reg <= ST_ACK;
                    end else if (!Dbg_Halt) begin
                        state_reg  <= ST_RUN;
                        halted_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= ST_RUN;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

    assign Dbg_Ack    = dbg_ack_reg;
    assign Dbg_R_Data = dbg_r_data_reg;
    assign Halted     = halted_reg;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port `data_memory` between the pipeline Memory stage (core port) and a debug/loader port.
- Drives the `data_memory` control/address/write-data inputs and stalls the core when it loses a cycle.
- Core has fixed priority, with a starvation limit that guarantees debug progress.
- A debug halt mode gives the debug port exclusive access for program load and inspection.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles debug may wait while the core holds memory; debug is then forced a grant. Legal range 1..15.
- CNT_W, $clog2(STARVE_LIMIT+1): starvation counter width. Derived; never overridden.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  asynchronous active-low reset.
- Core_Req  in  1  Memory stage needs memory this cycle (load or store).
- Core_W_En  in  1  core store.
- Core_Control  in  3  MEM_* access size/sign code from definitions.
- Core_Addr  in  32  core address.
- Core_W_Data  in  32  core store data.
- Core_R_Data  out  32  read data to core; combinational from MEM_Data_Out; valid only when granted.
- Core_Stall  out  1  core must hold its request and freeze the pipeline.
- Dbg_Req  in  1  debug request; held with stable fields until Dbg_Ack.
- Dbg_W_En  in  1  debug store.
- Dbg_Control  in  3  MEM_* code.
- Dbg_Addr  in  32  debug address.
- Dbg_W_Data  in  32  debug store data.
- Dbg_R_Data  out  32  registered read data.
- Dbg_Ack  out  1  one-cycle pulse, the cycle after the debug access.
- Dbg_Halt  in  1  level; requests exclusive debug ownership.
- Halted  out  1  registered; core is locked out.
- MEM_W_En  out  1  to data_memory.
- MEM_Control  out  3  to data_memory.
- MEM_Addr  out  32  to data_memory ALU_Out.
- MEM_W_Data  out  32  to data_memory REG_R_Data2.
- MEM_Data_Out  in  32  from data_memory Data_Out.

Behaviour:
- Reset (async, RST_N=0):
  - state=ST_RUN, starve_cnt=0, Dbg_Ack=0, Dbg_R_Data=0, Halted=0.
  - Combinational outputs follow the grant logic below, so with no requests MEM_W_En=0 and Core_Stall=0.
- Grant selection is combinational from state, starve_cnt and requests; exactly one or zero grants per cycle.
  - ST_RUN: dbg_grant = Dbg_Req && (!Core_Req || starve_cnt==STARVE_LIMIT); otherwise core_grant = Core_Req.
  - ST_ACK: dbg_grant=0; core_grant=Core_Req && !Halted.
  - ST_HALT: core_grant=0; dbg_grant=Dbg_Req.
- Memory mux:
  - The granted port's W_En/Control/Addr/W_Data drive the MEM_* outputs.
  - No grant: MEM_W_En=0, MEM_Control=core value, MEM_Addr=core value, MEM_W_Data=0.
  - Write protection: MEM_W_En is never high without a grant.
- Core side:
  - Core_Stall = Core_Req && !core_grant.
  - Core_R_Data = MEM_Data_Out, zero latency.
- Debug access:
  - On a dbg_grant cycle, Dbg_R_Data <= MEM_Data_Out (reads and writes alike).
  - Dbg_Ack <= 1 for exactly one cycle; state <= ST_ACK.
- ST_ACK lasts one cycle and blocks re-grant of a still-high Dbg_Req.
  - Next state: ST_HALT if Dbg_Halt, else ST_RUN.
- Halt:
  - In ST_RUN, Dbg_Halt=1 moves to ST_HALT next cycle and sets Halted=1.
  - A core access granted in the same cycle completes normally.
  - In ST_HALT, Dbg_Halt=0 returns to ST_RUN and clears Halted next cycle.
  - Halted stays 1 through ST_ACK entered from ST_HALT.
- Starvation counter (ST_RUN only):
  - Increments when Dbg_Req && core_grant.
  - Clears on dbg_grant, when Dbg_Req=0, and on any state other than ST_RUN.
  - Saturates at STARVE_LIMIT, so debug is forced on the (STARVE_LIMIT+1)th contended cycle.
- Simultaneous events:
  - Core and debug requests at starve_cnt==STARVE_LIMIT: debug wins and the core stalls one cycle.
  - Dbg_Halt rising while a debug grant occurs: the ack sequence takes precedence, then ST_ACK exits to ST_HALT.
- Reset mid-operation:
  - A granted-but-unacked debug access gets no Dbg_Ack; the debug master must reissue.
  - Any store already clocked into memory persists.

Decomposition:
- Package `definitions` gains:
  - `arb_state_t` enum {ST_RUN, ST_ACK, ST_HALT}.
  - `ARB_PORT_CORE` / `ARB_PORT_DBG` select constants.
  - The existing MEM_* codes are reused unchanged.
- One sub-module, `arb_starve_counter`: saturating counter with inc/clr inputs and an `at_limit` output, parameterised by STARVE_LIMIT.

Test Plan:
- Core-only traffic:
  - Stimulus: Core_Req=1, Core_W_En=1, MEM_WORD, addr 0x10, data 0xDEADBEEF; next cycle a read of 0x10.
  - Required: Core_Stall=0 both cycles; Core_R_Data=0xDEADBEEF.
- Debug-only traffic:
  - Stimulus: Dbg_Req held, MEM_BYTE store 0x5A to addr 0x04.
  - Required: Dbg_Ack pulses at cycle+1; Dbg_Req still high in ST_ACK causes no second write.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: continuous Core_Req plus a debug read of 0x10.
  - Required: core granted 4 cycles, then Core_Stall=1 and the debug grant on the 5th; Dbg_R_Data=0xDEADBEEF and Dbg_Ack on the 6th.
- Halt:
  - Stimulus: Dbg_Halt=1 with continuous Core_Req.
  - Required: Halted=1 and Core_Stall=1 from the next cycle; two debug writes ack on alternating cycles.
  - Stimulus: release Dbg_Halt.
  - Required: Halted=0 and the core resumes one cycle later.
- Async reset during a debug grant cycle:
  - Required: Dbg_Ack never asserts, Halted=0, state ST_RUN, MEM_W_En=0 with no requests.
- Halfword debug read:
  - Stimulus: MEM_HALFWORD_UNSIGNED read after a core store of 0xFFFF8001.
  - Required: Dbg_R_Data=0x00008001.
  - Stimulus: same read with MEM_HALFWORD.
  - Required: Dbg_R_Data=0xFFFF8001.
